// File: rtl/response_checker.sv
// -----------------------------------------------------------------------------
// response_checker
//
// Response-side checker for the gate-level logic test flow. It accepts a stream
// of expected entries (timestamp, value, care-mask, last flag) over a
// valid/ready handshake. It compares the response wires against each entry on
// the cycle whose timer value equals the entry timestamp. It counts failures,
// latches the first one and reports a pass/fail verdict once the last entry
// has been checked.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : synchronous active-low reset
//   start          : pulse, begins a run from IDLE or DONE
//   resp           : response wires from the design under test
//   exp_valid      : expected entry present
//   exp_ready      : checker accepts an entry this cycle
//   exp_time       : timer value at which resp is compared
//   exp_data       : expected response value
//   exp_mask       : 1 = bit checked, 0 = don't care
//   exp_last       : final entry of the run
//   busy           : run in progress (WAIT or ARMED)
//   done           : run complete
//   pass           : valid while done; no failures and no ordering error
//   order_err      : sticky, an entry arrived after its timestamp
//   mismatch_count : failed checks, saturating
//   fail_valid     : a first failure has been latched
//   fail_time      : timer value at the first failure
//   fail_got       : resp sampled at the first failure
// -----------------------------------------------------------------------------
module response_checker #(
  parameter int WIDTH  = 2,
  parameter int TIME_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  resp,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [TIME_W-1:0] exp_time,
  input  logic [WIDTH-1:0]  exp_data,
  input  logic [WIDTH-1:0]  exp_mask,
  input  logic              exp_last,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              order_err,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              fail_valid,
  output logic [TIME_W-1:0] fail_time,
  output logic [WIDTH-1:0]  fail_got
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ARMED,
    S_DONE
  } state_t;

  state_t            state;
  logic [TIME_W-1:0] timer;

  // Held expected entry (registered on acceptance).
  logic [TIME_W-1:0] hold_time_p1;
  logic [WIDTH-1:0]  hold_data_p1;
  logic [WIDTH-1:0]  hold_mask_p1;
  logic              hold_last_p1;

  logic              cmp_hit;
  logic              late;
  logic              chk_evt;
  logic              fail_now;
  logic              accept;

  function automatic logic [TIME_W-1:0] timer_inc(input logic [TIME_W-1:0] t);
    return (t == '1) ? t : t + TIME_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // The timer only moves forward one step per cycle, so a held timestamp that
  // is behind the timer in ARMED can only have been behind on the first ARMED
  // cycle; otherwise equality would have been hit first. A saturated timer
  // keeps older timestamps late while still matching a timestamp of all-ones.
  assign cmp_hit  = (state == S_ARMED) && (timer == hold_time_p1);
  assign late     = (state == S_ARMED) && (hold_time_p1 < timer);
  assign chk_evt  = cmp_hit || late;
  assign fail_now = late || (((resp ^ hold_data_p1) & hold_mask_p1) != '0);

  assign exp_ready = (state == S_WAIT) || (chk_evt && !hold_last_p1);
  assign accept    = exp_valid && exp_ready;

  assign busy = (state == S_WAIT) || (state == S_ARMED);
  assign done = (state == S_DONE);
  assign pass = (state == S_DONE) && (mismatch_count == '0) && !order_err;

  // Entry capture: data path, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_time_p1 <= exp_time;
      hold_data_p1 <= exp_data;
      hold_mask_p1 <= exp_mask;
    end
  end

  // Control, timer, counters and verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      timer          <= '0;
      hold_last_p1   <= 1'b0;
      order_err      <= 1'b0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_time      <= '0;
      fail_got       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WAIT;
            timer          <= '0;
            hold_last_p1   <= 1'b0;
            order_err      <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            fail_time      <= '0;
            fail_got       <= '0;
          end
        end

        S_WAIT: begin
          timer <= timer_inc(timer);
          if (accept) begin
            hold_last_p1 <= exp_last;
            state        <= S_ARMED;
          end
        end

        S_ARMED: begin
          timer <= timer_inc(timer);
          if (chk_evt) begin
            if (fail_now) begin
              mismatch_count <= cnt_inc(mismatch_count);
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_time  <= timer;
                fail_got   <= resp;
              end
            end
            if (late) begin
              order_err <= 1'b1;
            end
            if (hold_last_p1) begin
              state <= S_DONE;
            end else if (accept) begin
              hold_last_p1 <= exp_last;
              state        <= S_ARMED;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_response_checker.sv
module tb_response_checker;

  localparam int WIDTH  = 2;
  localparam int TIME_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  resp;
  logic              exp_valid;
  logic              exp_ready;
  logic [TIME_W-1:0] exp_time;
  logic [WIDTH-1:0]  exp_data;
  logic [WIDTH-1:0]  exp_mask;
  logic              exp_last;
  logic              busy;
  logic              done;
  logic              pass;
  logic              order_err;
  logic [CNT_W-1:0]  mismatch_count;
  logic              fail_valid;
  logic [TIME_W-1:0] fail_time;
  logic [WIDTH-1:0]  fail_got;

  always #5 clk = ~clk;

  response_checker #(
    .WIDTH (WIDTH),
    .TIME_W(TIME_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .resp          (resp),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_time      (exp_time),
    .exp_data      (exp_data),
    .exp_mask      (exp_mask),
    .exp_last      (exp_last),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .order_err     (order_err),
    .mismatch_count(mismatch_count),
    .fail_valid    (fail_valid),
    .fail_time     (fail_time),
    .fail_got      (fail_got)
  );

  typedef struct {
    int         avail;
    int         t;
    logic [1:0] d;
    logic [1:0] m;
    logic       last;
  } ent_t;

  typedef struct {
    logic       pass;
    logic       oerr;
    int         cnt;
    logic       fv;
    int         ft;
    logic [1:0] fg;
    int         done_t;
  } exp_t;

  ent_t drv_q[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // AND/OR pair: inputs (a,b) step through 00,01,10,11 at t = 0,2,4,6 and then
  // hold; resp = {a|b, a&b}.
  function automatic logic [1:0] pat(input int t);
    int   idx;
    logic a;
    logic b;
    idx = (t >= 6) ? 3 : t / 2;
    a   = idx[1];
    b   = idx[0];
    return {a | b, a & b};
  endfunction

  task automatic add(input int avail, input int t, input logic [1:0] d,
                     input logic [1:0] m, input logic last);
    ent_t e;
    e.avail = avail;
    e.t     = t;
    e.d     = d;
    e.m     = m;
    e.last  = last;
    drv_q.push_back(e);
  endtask

  task automatic expect_run(input logic p, input logic oe, input int cnt, input logic fv,
                            input int ft, input logic [1:0] fg, input int dt);
    exp_t e;
    e.pass   = p;
    e.oerr   = oe;
    e.cnt    = cnt;
    e.fv     = fv;
    e.ft     = ft;
    e.fg     = fg;
    e.done_t = dt;
    sb_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_exp_ready"}, 32'(exp_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_order_err"}, 32'(order_err), 0);
    chk({tag, "_count"}, 32'(mismatch_count), 0);
    chk({tag, "_fail_valid"}, 32'(fail_valid), 0);
    chk({tag, "_fail_time"}, 32'(fail_time), 0);
    chk({tag, "_fail_got"}, 32'(fail_got), 0);
  endtask

  // Drives one run from the entry queue; pops the expected verdict from the
  // scoreboard once done rises (or the cycle budget expires).
  task automatic run_case(input string tag);
    int   tnow;
    int   done_t;
    logic hs;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    exp_valid = 1'b0;
    @(posedge clk);
    tnow   = 0;
    done_t = -1;
    while (tnow < 600) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_t = tnow;
        break;
      end
      if (tnow == 0) chk({tag, "_busy0"}, 32'(busy), 1);
      resp = pat(tnow);
      if (drv_q.size() > 0 && tnow >= drv_q[0].avail) begin
        exp_valid = 1'b1;
        exp_time  = TIME_W'(drv_q[0].t);
        exp_data  = drv_q[0].d;
        exp_mask  = drv_q[0].m;
        exp_last  = drv_q[0].last;
      end else begin
        exp_valid = 1'b0;
      end
      #1;
      hs = exp_valid && exp_ready;
      @(posedge clk);
      if (hs) void'(drv_q.pop_front());
      tnow++;
    end
    exp_valid = 1'b0;
    drv_q.delete();
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_done_t"}, 32'(done_t), 32'(e.done_t));
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
      chk({tag, "_order_err"}, 32'(order_err), 32'(e.oerr));
      chk({tag, "_count"}, 32'(mismatch_count), 32'(e.cnt));
      chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(e.fv));
      chk({tag, "_fail_time"}, 32'(fail_time), 32'(e.ft));
      chk({tag, "_fail_got"}, 32'(fail_got), 32'(e.fg));
      chk({tag, "_busy_end"}, 32'(busy), 0);
    end
  endtask

  task automatic load_good();
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 3, 2'b10, 2'b11, 1'b0);
    add(0, 5, 2'b10, 2'b11, 1'b0);
    add(0, 7, 2'b11, 2'b11, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    resp      = '0;
    exp_valid = 1'b0;
    exp_time  = '0;
    exp_data  = '0;
    exp_mask  = '0;
    exp_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // All correct.
    load_good();
    expect_run(1, 0, 0, 0, 0, 2'b00, 8);
    run_case("good");

    // Injected fault at t=3.
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 3, 2'b01, 2'b11, 1'b0);
    add(0, 5, 2'b10, 2'b11, 1'b0);
    add(0, 7, 2'b11, 2'b11, 1'b1);
    expect_run(0, 0, 1, 1, 3, 2'b10, 8);
    run_case("fault");

    // Same fault fully masked.
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 3, 2'b01, 2'b00, 1'b0);
    add(0, 5, 2'b10, 2'b11, 1'b0);
    add(0, 7, 2'b11, 2'b11, 1'b1);
    expect_run(1, 0, 0, 0, 0, 2'b00, 8);
    run_case("mask");

    // Masked fault plus a real fault at t=7.
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 3, 2'b01, 2'b00, 1'b0);
    add(0, 5, 2'b10, 2'b11, 1'b0);
    add(0, 7, 2'b00, 2'b11, 1'b1);
    expect_run(0, 0, 1, 1, 7, 2'b11, 8);
    run_case("mask_f7");

    // Two faults: first one stays latched.
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 3, 2'b01, 2'b11, 1'b0);
    add(0, 5, 2'b10, 2'b11, 1'b0);
    add(0, 7, 2'b00, 2'b11, 1'b1);
    expect_run(0, 0, 2, 1, 3, 2'b10, 8);
    run_case("two_fault");

    // Late entry: offered at timer 6 with timestamp 3.
    add(6, 3, 2'b11, 2'b11, 1'b1);
    expect_run(0, 1, 1, 1, 7, 2'b11, 8);
    run_case("late");

    // Back-to-back timestamps 1,2,3.
    add(0, 1, 2'b00, 2'b11, 1'b0);
    add(0, 2, 2'b10, 2'b11, 1'b0);
    add(0, 3, 2'b10, 2'b11, 1'b1);
    expect_run(1, 0, 0, 0, 0, 2'b00, 4);
    run_case("b2b");

    // Timestamp at the saturated timer value is checked normally.
    add(250, 255, 2'b11, 2'b11, 1'b1);
    expect_run(1, 0, 0, 0, 0, 2'b00, 256);
    run_case("tsat_ok");

    // Older timestamp against a saturated timer is late.
    add(260, 254, 2'b11, 2'b11, 1'b1);
    expect_run(0, 1, 1, 1, 255, 2'b11, 262);
    run_case("tsat_late");

    // 300 late entries: the counter saturates instead of wrapping.
    for (int i = 0; i < 300; i++) add(0, 0, 2'b00, 2'b11, (i == 299));
    expect_run(0, 1, 255, 1, 1, 2'b00, 301);
    run_case("cnt_sat");

    // Reset while ARMED aborts the run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    resp      = pat(0);
    exp_valid = 1'b1;
    exp_time  = 8'd50;
    exp_data  = 2'b11;
    exp_mask  = 2'b11;
    exp_last  = 1'b1;
    #1;
    chk("abort_ready_wait", 32'(exp_ready), 1);
    @(posedge clk);
    @(negedge clk);
    exp_valid = 1'b0;
    chk("abort_busy_armed", 32'(busy), 1);
    chk("abort_ready_armed", 32'(exp_ready), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort");
    rst_n = 1'b1;

    // Fresh run after the abort.
    load_good();
    expect_run(1, 0, 0, 0, 0, 2'b00, 8);
    run_case("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
